// File: rtl/approx_mult_pipe_if.sv
// approx_mult_pipe_if: operand/result handshake bundle for approx_mult_pipe.
//   in_valid/in_ready         operand handshake (source -> multiplier)
//   in_a, in_b, in_mode       operands and per-transaction mode (1 = approximate)
//   out_valid/out_ready       result handshake (multiplier -> accumulator)
//   out_result, out_mode      product and the mode it was computed in
//   err_cnt                   count of inexact approximate results (zero unless enabled)
// Modports: slave = multiplier side, master = operand source / result sink side.
interface approx_mult_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_mode;
    logic [CNT_W-1:0]     err_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_result, out_mode, err_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_result, out_mode, err_cnt
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage pipelined unsigned WIDTH x WIDTH multiplier with a
// per-transaction approximate mode. In approximate mode the lowest APPROX_COLS
// partial-product columns are OR-compressed with no carry out; the remaining
// columns are summed exactly.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    approx_mult_pipe_if.slave (operand and result valid/ready handshakes)
// Stages: S1 operands, S2 low-column OR bits + two half partial sums, S3 result.
// Optional macro APPROX_ERR_STAT_EN adds an exact shadow path and a saturating
// count of inexact approximate results on err_cnt; without it err_cnt is 0.
module approx_mult_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    approx_mult_pipe_if.slave bus
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned HALF = WIDTH / 2;
    // Bit c set for every approximated column c < APPROX_COLS.
    localparam logic [PW-1:0] LOW_MASK = (PW'(1) << APPROX_COLS) - PW'(1);

    logic stall;

    logic             s1_valid, s1_mode;
    logic [WIDTH-1:0] s1_a, s1_b;

    logic          s2_valid, s2_mode;
    logic [PW-1:0] s2_low_or, s2_sum_lo, s2_sum_hi;
    logic [PW-1:0] low_or_d, sum_lo_d, sum_hi_d;

    logic          s3_valid, s3_mode;
    logic [PW-1:0] s3_result;

`ifdef APPROX_ERR_STAT_EN
    logic [PW-1:0]    s2_ex_lo, s2_ex_hi, ex_lo_d, ex_hi_d;
    logic [PW-1:0]    s3_exact;
    logic [CNT_W-1:0] err_q;
`endif

    // Whole pipe freezes while the head result is refused; bubbles are kept.
    assign stall        = s3_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= bus.in_mode;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
        end
    end

    // Each shifted row holds pp[i][j] at column i+j, so OR-ing rows gives the
    // per-column OR and masked row sums give the exact upper-column sum.
    always_comb begin
        logic [PW-1:0] row;
        logic [PW-1:0] col_mask;
        logic [PW-1:0] low_all;
        row      = '0;
        col_mask = s1_mode ? ~LOW_MASK : '1;
        low_all  = '0;
        sum_lo_d = '0;
        sum_hi_d = '0;
`ifdef APPROX_ERR_STAT_EN
        ex_lo_d  = '0;
        ex_hi_d  = '0;
`endif
        for (int j = 0; j < int'(WIDTH); j++) begin
            row     = s1_b[j] ? (PW'(s1_a) << j) : '0;
            low_all = low_all | row;
            if (j < int'(HALF)) begin
                sum_lo_d = sum_lo_d + (row & col_mask);
`ifdef APPROX_ERR_STAT_EN
                ex_lo_d  = ex_lo_d + row;
`endif
            end else begin
                sum_hi_d = sum_hi_d + (row & col_mask);
`ifdef APPROX_ERR_STAT_EN
                ex_hi_d  = ex_hi_d + row;
`endif
            end
        end
        low_or_d = s1_mode ? (low_all & LOW_MASK) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_mode   <= 1'b0;
            s2_low_or <= '0;
            s2_sum_lo <= '0;
            s2_sum_hi <= '0;
        end else if (!stall) begin
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            s2_low_or <= low_or_d;
            s2_sum_lo <= sum_lo_d;
            s2_sum_hi <= sum_hi_d;
        end
    end

    // Low OR bits and upper sums occupy disjoint columns, so a plain add merges them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid  <= 1'b0;
            s3_mode   <= 1'b0;
            s3_result <= '0;
        end else if (!stall) begin
            s3_valid  <= s2_valid;
            s3_mode   <= s2_mode;
            s3_result <= s2_low_or + s2_sum_lo + s2_sum_hi;
        end
    end

    assign bus.out_valid  = s3_valid;
    assign bus.out_mode   = s3_mode;
    assign bus.out_result = s3_result;

`ifdef APPROX_ERR_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ex_lo <= '0;
            s2_ex_hi <= '0;
            s3_exact <= '0;
        end else if (!stall) begin
            s2_ex_lo <= ex_lo_d;
            s2_ex_hi <= ex_hi_d;
            s3_exact <= s2_ex_lo + s2_ex_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (s3_valid && bus.out_ready && s3_mode &&
                     (s3_result != s3_exact) && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif
endmodule
